// File: rtl/turn_scheduler.sv
// turn_scheduler: two-player turn controller for the 2x4 board cursor.
// Hands the shared cursor to one player at a time, records cell claims and
// scores, and declares the winner once all eight cells are taken.
// Optional feature: define TURN_TIMEOUT_EN to build the per-turn timer
// (tick decrements time_left; reaching zero forfeits the turn). Without it,
// tick is ignored and time_left stays at TURN_TIME.
module turn_scheduler #(
  parameter int TURN_TIME = 9,
  parameter int TIMER_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               tick,
  input  logic               confirm,
  input  logic [2:0]         area,
  output logic               area_en,
  output logic               finish,
  output logic               player,
  output logic [7:0]         owner0,
  output logic [7:0]         owner1,
  output logic [3:0]         score0,
  output logic [3:0]         score1,
  output logic [TIMER_W-1:0] time_left,
  output logic               err,
  output logic [1:0]         winner
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_SWAP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(TURN_TIME);

  // Winner code from final scores: 01 player 0, 10 player 1, 11 tie.
  function automatic logic [1:0] winner_of(input logic [3:0] s0, input logic [3:0] s1);
    logic [1:0] w;
    if (s0 > s1) begin
      w = 2'b01;
    end else if (s1 > s0) begin
      w = 2'b10;
    end else begin
      w = 2'b11;
    end
    return w;
  endfunction

  state_t             state_r, state_s;
  logic               player_r, player_s;
  logic [7:0]         owner0_r, owner0_s;
  logic [7:0]         owner1_r, owner1_s;
  logic [3:0]         score0_r, score0_s;
  logic [3:0]         score1_r, score1_s;
  logic [TIMER_W-1:0] time_left_r, time_left_s;
  logic               err_r, err_s;
  logic [1:0]         winner_r, winner_s;
  logic               area_en_r, area_en_s;
  logic               finish_r, finish_s;
  logic               cprev_r;
  logic               press_s;
  logic [7:0]         cell_mask_s;
  logic               occupied_s;

`ifndef TURN_TIMEOUT_EN
  // Without the timer the tick input has no consumer.
  logic unused_tick_s;
  assign unused_tick_s = tick;
`endif

  // A press is the falling edge of the active-low button; holding it yields one press.
  assign press_s     = ~confirm & cprev_r;
  assign cell_mask_s = 8'h01 << area;
  assign occupied_s  = |((owner0_r | owner1_r) & cell_mask_s);

  // Next-state and next-output computation for the turn FSM.
  always_comb begin
    state_s     = state_r;
    player_s    = player_r;
    owner0_s    = owner0_r;
    owner1_s    = owner1_r;
    score0_s    = score0_r;
    score1_s    = score1_r;
    time_left_s = time_left_r;
    err_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s     = ST_TURN;
          player_s    = 1'b0;
          time_left_s = RELOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_TURN: begin
        if (press_s) begin
          // A press wins over a coincident tick: the timer is left alone.
          if (occupied_s) begin
            err_s = 1'b1;
          end else if (player_r == 1'b0) begin
            owner0_s = owner0_r | cell_mask_s;
            score0_s = score0_r + 4'd1;
            state_s  = ST_SWAP;
          end else begin
            owner1_s = owner1_r | cell_mask_s;
            score1_s = score1_r + 4'd1;
            state_s  = ST_SWAP;
          end
        end else begin
`ifdef TURN_TIMEOUT_EN
          if (tick) begin
            time_left_s = time_left_r - {{(TIMER_W-1){1'b0}}, 1'b1};
            if (time_left_r == {{(TIMER_W-1){1'b0}}, 1'b1}) begin
              state_s = ST_SWAP;
            end else begin
              state_s = ST_TURN;
            end
          end else begin
            state_s = ST_TURN;
          end
`else
          state_s = ST_TURN;
`endif
        end
      end
      ST_SWAP: begin
        if ((owner0_r | owner1_r) == 8'hFF) begin
          state_s = ST_DONE;
        end else begin
          player_s    = ~player_r;
          time_left_s = RELOAD;
          state_s     = ST_TURN;
        end
      end
      ST_DONE: begin
        state_s = ST_DONE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    area_en_s = (state_s == ST_TURN);
    finish_s  = (state_s == ST_DONE);
    if (state_s == ST_DONE) begin
      winner_s = winner_of(score0_s, score1_s);
    end else begin
      winner_s = 2'b00;
    end
  end

  // State and registered-output update with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      player_r    <= 1'b0;
      owner0_r    <= 8'h00;
      owner1_r    <= 8'h00;
      score0_r    <= 4'd0;
      score1_r    <= 4'd0;
      time_left_r <= RELOAD;
      err_r       <= 1'b0;
      winner_r    <= 2'b00;
      area_en_r   <= 1'b0;
      finish_r    <= 1'b0;
      cprev_r     <= 1'b1;
    end else begin
      state_r     <= state_s;
      player_r    <= player_s;
      owner0_r    <= owner0_s;
      owner1_r    <= owner1_s;
      score0_r    <= score0_s;
      score1_r    <= score1_s;
      time_left_r <= time_left_s;
      err_r       <= err_s;
      winner_r    <= winner_s;
      area_en_r   <= area_en_s;
      finish_r    <= finish_s;
      cprev_r     <= confirm;
    end
  end

  assign area_en   = area_en_r;
  assign finish    = finish_r;
  assign player    = player_r;
  assign owner0    = owner0_r;
  assign owner1    = owner1_r;
  assign score0    = score0_r;
  assign score1    = score1_r;
  assign time_left = time_left_r;
  assign err       = err_r;
  assign winner    = winner_r;

endmodule

// File: tb/tb_turn_scheduler.sv
// Testbench for turn_scheduler: table vectors, directed multi-cycle sequences
// and random stimulus against a board-level reference model.
`timescale 1ns/1ps
module tb_turn_scheduler;

  localparam int TT = 9;
  localparam int TW = 4;
`ifdef TURN_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset, start, tick, confirm;
  logic [2:0]    area;
  logic          area_en, finish, player, err;
  logic [7:0]    owner0, owner1;
  logic [3:0]    score0, score1;
  logic [TW-1:0] time_left;
  logic [1:0]    winner;

  turn_scheduler #(.TURN_TIME(TT), .TIMER_W(TW)) dut (
    .clock(clock), .reset(reset), .start(start), .tick(tick), .confirm(confirm),
    .area(area), .area_en(area_en), .finish(finish), .player(player),
    .owner0(owner0), .owner1(owner1), .score0(score0), .score1(score1),
    .time_left(time_left), .err(err), .winner(winner)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: game phase, whose turn, who owns each cell (-1 free).
  localparam int PH_IDLE = 0, PH_PLAY = 1, PH_HAND = 2, PH_OVER = 3;
  int m_phase;
  int m_player;
  int m_own[8];
  int m_tl;
  bit m_err;
  bit m_prev;

  function automatic int count_of(input int who);
    int n = 0;
    for (int i = 0; i < 8; i++) if (m_own[i] == who) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit press;
    if (reset == 1'b0) begin
      m_phase = PH_IDLE; m_player = 0; m_tl = TT; m_err = 1'b0; m_prev = 1'b1;
      for (int i = 0; i < 8; i++) m_own[i] = -1;
    end else begin
      press  = (confirm == 1'b0) && m_prev;
      m_prev = confirm;
      m_err  = 1'b0;
      case (m_phase)
        PH_IDLE: if (start) begin m_phase = PH_PLAY; m_player = 0; m_tl = TT; end
        PH_PLAY: begin
          if (press) begin
            if (m_own[area] != -1) m_err = 1'b1;
            else begin m_own[area] = m_player; m_phase = PH_HAND; end
          end else if (TIMEOUT && tick) begin
            m_tl = m_tl - 1;
            if (m_tl == 0) m_phase = PH_HAND;
          end
        end
        PH_HAND: begin
          if (count_of(-1) == 0) m_phase = PH_OVER;
          else begin m_player = 1 - m_player; m_tl = TT; m_phase = PH_PLAY; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] e0, e1;
    int c0, c1, w;
    for (int i = 0; i < 8; i++) begin
      e0[i] = (m_own[i] == 0);
      e1[i] = (m_own[i] == 1);
    end
    c0 = count_of(0);
    c1 = count_of(1);
    if (m_phase != PH_OVER) w = 0;
    else if (c0 > c1) w = 1;
    else if (c1 > c0) w = 2;
    else w = 3;
    chk({tag, ".area_en"}, 32'(area_en), 32'(m_phase == PH_PLAY));
    chk({tag, ".finish"}, 32'(finish), 32'(m_phase == PH_OVER));
    chk({tag, ".player"}, 32'(player), 32'(m_player));
    chk({tag, ".owner0"}, 32'(owner0), 32'(e0));
    chk({tag, ".owner1"}, 32'(owner1), 32'(e1));
    chk({tag, ".score0"}, 32'(score0), 32'(c0));
    chk({tag, ".score1"}, 32'(score1), 32'(c1));
    chk({tag, ".time_left"}, 32'(time_left), 32'(m_tl));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".winner"}, 32'(winner), 32'(w));
  endtask

  task automatic drive(input bit r, input bit s, input bit t, input bit c, input int a);
    reset = r; start = s; tick = t; confirm = c; area = 3'(a);
  endtask

  // One clock: model follows the edge, outputs sampled on the falling edge.
  task automatic cycle(input string tag);
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_model(tag);
  endtask

  task automatic new_game();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0); cycle("rst");
    drive(1'b1, 1'b1, 1'b0, 1'b1, 0); cycle("start");
  endtask

  task automatic claim(input int a);
    drive(1'b1, 1'b1, 1'b0, 1'b0, a); cycle("claim");
    drive(1'b1, 1'b1, 1'b0, 1'b1, a); cycle("swap");
  endtask

  typedef struct {
    bit rst; bit st; bit cf; int ar;
    bit e_player; logic [7:0] e_o0; logic [7:0] e_o1;
    logic [3:0] e_s0; logic [3:0] e_s1; bit e_err; bit e_aen;
  } vec_t;
  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 3, 1'b0, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 3, 1'b0, 8'h08, 8'h00, 4'd1, 4'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 3, 1'b1, 8'h08, 8'h00, 4'd1, 4'd0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 3, 1'b1, 8'h08, 8'h00, 4'd1, 4'd0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 3, 1'b1, 8'h08, 8'h00, 4'd1, 4'd0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 3, 1'b1, 8'h08, 8'h00, 4'd1, 4'd0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 5, 1'b1, 8'h08, 8'h20, 4'd1, 4'd1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 5, 1'b0, 8'h08, 8'h20, 4'd1, 4'd1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 5, 1'b0, 8'h08, 8'h20, 4'd1, 4'd1, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 6, 1'b0, 8'h08, 8'h20, 4'd1, 4'd1, 1'b0, 1'b1};

    drive(1'b0, 1'b0, 1'b0, 1'b1, 0);

    // Table vectors (no ticks, so both builds agree).
    for (int v = 0; v < 11; v++) begin
      drive(vecs[v].rst, vecs[v].st, 1'b0, vecs[v].cf, vecs[v].ar);
      cycle("vec");
      chk($sformatf("vec%0d.player", v), 32'(player), 32'(vecs[v].e_player));
      chk($sformatf("vec%0d.owner0", v), 32'(owner0), 32'(vecs[v].e_o0));
      chk($sformatf("vec%0d.owner1", v), 32'(owner1), 32'(vecs[v].e_o1));
      chk($sformatf("vec%0d.score0", v), 32'(score0), 32'(vecs[v].e_s0));
      chk($sformatf("vec%0d.score1", v), 32'(score1), 32'(vecs[v].e_s1));
      chk($sformatf("vec%0d.err", v), 32'(err), 32'(vecs[v].e_err));
      chk($sformatf("vec%0d.area_en", v), 32'(area_en), 32'(vecs[v].e_aen));
    end

    // Button held low for 20 cycles gives a single claim.
    new_game();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 0); cycle("hold");
    end
    chk("hold.owner0", 32'(owner0), 32'h01);
    chk("hold.score0", 32'(score0), 32'd1);
    chk("hold.player", 32'(player), 32'd1);

    // Nine ticks without a press: forfeit only when the timer is built.
    new_game();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 0); cycle("settle");
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 0); cycle("tick");
    end
    chk("tmo.tl8", 32'(time_left), TIMEOUT ? 32'd1 : 32'd9);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 0); cycle("tick");
    chk("tmo.tl9", 32'(time_left), TIMEOUT ? 32'd0 : 32'd9);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 0); cycle("after");
    chk("tmo.player", 32'(player), TIMEOUT ? 32'd1 : 32'd0);
    chk("tmo.reload", 32'(time_left), 32'd9);
    chk("tmo.owners", 32'({owner0, owner1}), 32'h0000);

    // Tick coincident with a press: claim taken, no decrement.
    new_game();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 2); cycle("pretick");
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2); cycle("presstick");
    chk("pt.owner0", 32'(owner0), 32'h04);
    chk("pt.tl", 32'(time_left), TIMEOUT ? 32'd7 : 32'd9);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 2); cycle("pt.swap");
    chk("pt.player", 32'(player), 32'd1);
    chk("pt.reload", 32'(time_left), 32'd9);

    // Fill the board; with the timer player 1 forfeits once for a 5-3 result.
    new_game();
    for (int c = 0; c < 7; c++) claim(c);
`ifdef TURN_TIMEOUT_EN
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 7); cycle("forfeit");
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 7); cycle("forfeit.swap");
`endif
    claim(7);
    chk("done.finish", 32'(finish), 32'd1);
    chk("done.area_en", 32'(area_en), 32'd0);
    chk("done.winner", 32'(winner), TIMEOUT ? 32'd1 : 32'd3);
    chk("done.score0", 32'(score0), TIMEOUT ? 32'd5 : 32'd4);
    chk("done.score1", 32'(score1), TIMEOUT ? 32'd3 : 32'd4);
    claim(7);
    chk("done.ignored", 32'({score0, score1, err}), TIMEOUT ? 32'h0A6 : 32'h088);
    chk("done.held", 32'(finish), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 0); cycle("done.rst");
    chk("rst.finish", 32'(finish), 32'd0);
    chk("rst.winner", 32'(winner), 32'd0);
    chk("rst.owners", 32'({owner0, owner1}), 32'h0000);

    // Random play against the model.
    for (int n = 0; n < 4000; n++) begin
      drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0),
            int'($urandom_range(0, 7)));
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
